// File: rtl/motor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : motor_pkg                                                  |
// | Purpose : Shared definitions for the motor sequencer: the state      |
// |           encoding shown on the seven-segment display, the PWM width |
// |           size, and the duty-switch to compare-width decode.         |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package motor_pkg;

  localparam int c_width = 20;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_RUN   = 3'd2,
    ST_COAST = 3'd3,
    ST_DEAD  = 3'd4,
    ST_FAULT = 3'd5
  } motor_state_t;

  localparam logic [c_width-1:0] c_duty_none = 20'd0;
  localparam logic [c_width-1:0] c_duty_b0   = 20'd262143;
  localparam logic [c_width-1:0] c_duty_b1   = 20'd393215;
  localparam logic [c_width-1:0] c_duty_b2   = 20'd524287;
  localparam logic [c_width-1:0] c_duty_b3   = 20'd655359;
  localparam logic [c_width-1:0] c_duty_b4   = 20'd786431;
  localparam logic [c_width-1:0] c_duty_b5   = 20'd917503;
  localparam logic [c_width-1:0] c_duty_b6   = 20'd1048575;

  // The highest closed switch wins; lower switches are ignored.
  function automatic logic [c_width-1:0] duty_to_width(input logic [6:0] sel);
    logic [c_width-1:0] w;
    if (sel[6])      w = c_duty_b6;
    else if (sel[5]) w = c_duty_b5;
    else if (sel[4]) w = c_duty_b4;
    else if (sel[3]) w = c_duty_b3;
    else if (sel[2]) w = c_duty_b2;
    else if (sel[1]) w = c_duty_b1;
    else if (sel[0]) w = c_duty_b0;
    else             w = c_duty_none;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/motor_sequencer_ramp_tick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ramp_tick                                                  |
// | Purpose : Divides the clock into one-cycle ramp ticks, one every     |
// |           RAMP_DIV clocks, counted from the last restart.            |
// | Ports   : clock   - clock                                            |
// |           reset   - synchronous reset, active low                    |
// |           restart - high in the first cycle of a new FSM state       |
// |           tick    - one-cycle pulse every RAMP_DIV clocks            |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module ramp_tick #(
  parameter int unsigned RAMP_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int c_cnt_w = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_eff;

  // The first cycle of a new state counts as position 0, so the first tick
  // lands exactly RAMP_DIV clocks after the state was entered.
  assign w_cnt_eff = restart ? '0 : r_cnt;
  assign tick      = (w_cnt_eff == c_cnt_w'(RAMP_DIV - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_eff + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/motor_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : motor_sequencer                                            |
// | Purpose : Soft-start / soft-stop motor PWM sequencer with dead time  |
// |           on direction reversal and latched overcurrent shutdown.    |
// | Ports   : clock, reset (sync, active low)                            |
// |           dir_req  - requested direction (0 fwd, 1 back)             |
// |           duty_sel - duty switches, highest set bit selects level    |
// |           cin,cin2 - asynchronous overcurrent comparators            |
// |           width    - registered PWM compare width                    |
// |           dir      - applied direction                               |
// |           pwm_en   - drive enable                                    |
// |           fault    - latched overcurrent indication                  |
// |           state    - current state code for the display              |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module motor_sequencer
  import motor_pkg::*;
#(
  parameter int unsigned          RAMP_DIV    = 4,
  parameter logic [c_width-1:0]   RAMP_STEP   = 20'd65536,
  parameter int unsigned          DEAD_CYCLES = 8,
  parameter int unsigned          FAULT_HOLD  = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               dir_req,
  input  logic [6:0]         duty_sel,
  input  logic               cin,
  input  logic               cin2,
  output logic [c_width-1:0] width,
  output logic               dir,
  output logic               pwm_en,
  output logic               fault,
  output logic [2:0]         state
);

  localparam int c_dead_w = $clog2(DEAD_CYCLES + 1);
  localparam int c_hold_w = $clog2(FAULT_HOLD + 1);

  logic                r_cin_s1, r_cin_s2, r_cin2_s1, r_cin2_s2;
  logic                w_oc;
  logic [c_width-1:0]  w_target;
  logic                w_dir_mismatch;
  logic                w_stop;
  logic [c_width-1:0]  w_goal;
  logic [c_width:0]    w_sum;
  logic [c_width-1:0]  w_ramp_next;
  logic [c_width-1:0]  w_diff;
  logic [c_width-1:0]  w_coast_next;
  logic                w_restart;
  logic                w_tick;

  motor_state_t        r_state, r_state_d;
  logic [c_width-1:0]  r_width;
  logic                r_dir, r_pwm_en, r_fault;
  logic [c_dead_w-1:0] r_dead_cnt;
  logic [c_hold_w-1:0] r_hold_cnt;

  // Two-flop synchronizers for the asynchronous comparators.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cin_s1  <= 1'b0;
      r_cin_s2  <= 1'b0;
      r_cin2_s1 <= 1'b0;
      r_cin2_s2 <= 1'b0;
    end else begin
      r_cin_s1  <= cin;
      r_cin_s2  <= r_cin_s1;
      r_cin2_s1 <= cin2;
      r_cin2_s2 <= r_cin2_s1;
    end
  end

  assign w_oc           = r_cin_s2 | r_cin2_s2;
  assign w_target       = duty_to_width(duty_sel);
  assign w_dir_mismatch = (dir_req != r_dir);
  // Any reason to wind the drive down: reversal, lower target, or a zero
  // target (even at width 0, so that RUN never idles with drive enabled).
  assign w_stop         = w_dir_mismatch || (w_target < r_width) || (w_target == '0);
  assign w_goal         = (w_dir_mismatch || (w_target == '0)) ? '0 : w_target;

  // Ramp up with a 21-bit sum so the last step saturates instead of wrapping.
  assign w_sum        = {1'b0, r_width} + {1'b0, RAMP_STEP};
  assign w_ramp_next  = (w_sum > {1'b0, w_target}) ? w_target : w_sum[c_width-1:0];
  // Ramp down stops at the goal; only used while width > goal.
  assign w_diff       = r_width - w_goal;
  assign w_coast_next = (w_diff > RAMP_STEP) ? (r_width - RAMP_STEP) : w_goal;

  assign w_restart = (r_state != r_state_d);

  ramp_tick #(
    .RAMP_DIV (RAMP_DIV)
  ) u_ramp_tick (
    .clock   (clock),
    .reset   (reset),
    .restart (w_restart),
    .tick    (w_tick)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state_d <= ST_IDLE;
    end else begin
      r_state_d <= r_state;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_width    <= '0;
      r_dir      <= 1'b0;
      r_pwm_en   <= 1'b0;
      r_fault    <= 1'b0;
      r_dead_cnt <= '0;
      r_hold_cnt <= '0;
    end else if (w_oc) begin
      r_state    <= ST_FAULT;
      r_width    <= '0;
      r_pwm_en   <= 1'b0;
      r_fault    <= 1'b1;
      r_dead_cnt <= '0;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_width  <= '0;
          r_pwm_en <= 1'b0;
          if (w_target != '0) begin
            r_dir    <= dir_req;
            r_pwm_en <= 1'b1;
            r_state  <= ST_RAMP;
          end
        end
        ST_RAMP: begin
          if (w_stop) begin
            r_state <= ST_COAST;
          end else if (r_width == w_target) begin
            r_state <= ST_RUN;
          end else if (w_tick) begin
            r_width <= w_ramp_next;
          end
        end
        ST_RUN: begin
          if (w_stop) begin
            r_state <= ST_COAST;
          end else if (w_target > r_width) begin
            r_state <= ST_RAMP;
          end
        end
        ST_COAST: begin
          // A target raised above the current width ends the coast; RUN then
          // hands over to RAMP, so width never jumps upward here.
          if (r_width <= w_goal) begin
            r_dead_cnt <= '0;
            if (w_dir_mismatch) begin
              r_pwm_en <= 1'b0;
              r_state  <= ST_DEAD;
            end else if (w_goal == '0) begin
              r_pwm_en <= 1'b0;
              r_state  <= ST_IDLE;
            end else begin
              r_state <= ST_RUN;
            end
          end else if (w_tick) begin
            r_width <= w_coast_next;
          end
        end
        ST_DEAD: begin
          r_width  <= '0;
          r_pwm_en <= 1'b0;
          if (r_dead_cnt == c_dead_w'(DEAD_CYCLES - 1)) begin
            // Direction is taken as it stands at the end of the dead time.
            r_dead_cnt <= '0;
            r_dir      <= dir_req;
            if (w_target == '0) begin
              r_state <= ST_IDLE;
            end else begin
              r_pwm_en <= 1'b1;
              r_state  <= ST_RAMP;
            end
          end else begin
            r_dead_cnt <= r_dead_cnt + 1'b1;
          end
        end
        ST_FAULT: begin
          r_width  <= '0;
          r_pwm_en <= 1'b0;
          if (r_hold_cnt == c_hold_w'(FAULT_HOLD - 1)) begin
            r_hold_cnt <= '0;
            r_fault    <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: begin
          r_width  <= '0;
          r_pwm_en <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign width  = r_width;
  assign dir    = r_dir;
  assign pwm_en = r_pwm_en;
  assign fault  = r_fault;
  assign state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_motor_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_motor_sequencer                                         |
// | Purpose : Self-checking bench for motor_sequencer: directed          |
// |           scenarios plus a randomized run checked against rule-level |
// |           expectations (step sizes, dead time, fault timing).        |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_motor_sequencer;

  localparam int unsigned RAMP_DIV    = 4;
  localparam logic [19:0] RAMP_STEP   = 20'd65536;
  localparam int unsigned DEAD_CYCLES = 8;
  localparam int unsigned FAULT_HOLD  = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        dir_req = 1'b0;
  logic [6:0]  duty_sel = 7'd0;
  logic        cin = 1'b0;
  logic        cin2 = 1'b0;
  logic [19:0] width;
  logic        dir, pwm_en, fault;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  motor_sequencer #(
    .RAMP_DIV    (RAMP_DIV),
    .RAMP_STEP   (RAMP_STEP),
    .DEAD_CYCLES (DEAD_CYCLES),
    .FAULT_HOLD  (FAULT_HOLD)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .dir_req  (dir_req),
    .duty_sel (duty_sel),
    .cin      (cin),
    .cin2     (cin2),
    .width    (width),
    .dir      (dir),
    .pwm_en   (pwm_en),
    .fault    (fault),
    .state    (state)
  );

  always #5 clock = ~clock;

  // Level k+1 (highest set bit k) is (k+2)/8 of full scale, minus one.
  function automatic logic [19:0] ref_target(input logic [6:0] sel);
    int top;
    int v;
    top = -1;
    for (int k = 0; k < 7; k++) if (sel[k]) top = k;
    if (top < 0) return 20'd0;
    v = (top + 2) * 131072 - 1;
    return v[19:0];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] want, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max && n < 0; i++) begin
      step();
      if (state === want) n = i;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; duty_sel = 7'd0; dir_req = 1'b0; cin = 1'b0; cin2 = 1'b0;
    repeat (3) step();
    total++; if (state !== 3'd0)  begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if (width !== 20'd0) begin bad++; $display("FAIL reset_width got=%0d want=0", width); end
    total++; if (dir !== 1'b0)    begin bad++; $display("FAIL reset_dir got=%0b want=0", dir); end
    total++; if (pwm_en !== 1'b0) begin bad++; $display("FAIL reset_pwm_en got=%0b want=0", pwm_en); end
    total++; if (fault !== 1'b0)  begin bad++; $display("FAIL reset_fault got=%0b want=0", fault); end
    reset = 1'b1;
    repeat (3) step();
    total++; if (state !== 3'd0)  begin bad++; $display("FAIL idle_no_duty got=%0d want=0", state); end
  endtask

  task automatic test_ramp_up();
    logic [19:0] tgt, prev;
    int n, since, e;
    bit done;
    tgt = ref_target(7'h04);
    dir_req = 1'b0; duty_sel = 7'h04;
    wait_state(3'd1, 10, n);
    total++; if (n < 0) begin bad++; $display("FAIL ramp_entry got=%0d want=1", state); end
    total++; if (width !== 20'd0) begin bad++; $display("FAIL ramp_start_width got=%0d want=0", width); end
    prev = 20'd0; since = 0; done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      step(); since++;
      if (width !== prev) begin
        e = int'(prev) + int'(RAMP_STEP);
        if (e > int'(tgt)) e = int'(tgt);
        total++; if (width !== e[19:0]) begin bad++; $display("FAIL ramp_step got=%0d want=%0d", width, e); end
        total++; if (since != int'(RAMP_DIV)) begin bad++; $display("FAIL ramp_interval got=%0d want=%0d", since, RAMP_DIV); end
        prev = width; since = 0;
      end
      if (state === 3'd2) done = 1'b1;
    end
    total++; if (!done) begin bad++; $display("FAIL ramp_timeout got=%0d want=2", state); end
    total++; if (width !== tgt) begin bad++; $display("FAIL run_width got=%0d want=%0d", width, tgt); end
    total++; if (pwm_en !== 1'b1) begin bad++; $display("FAIL run_pwm_en got=%0b want=1", pwm_en); end
    total++; if (dir !== 1'b0) begin bad++; $display("FAIL run_dir got=%0b want=0", dir); end
  endtask

  task automatic test_dir_swap();
    logic [19:0] tgt, prev;
    int n, dead, e;
    tgt = ref_target(7'h04);
    dir_req = 1'b1;
    wait_state(3'd3, 5, n);
    total++; if (n < 0) begin bad++; $display("FAIL swap_coast got=%0d want=3", state); end
    prev = width;
    for (int i = 0; i < 300 && state === 3'd3; i++) begin
      step();
      if (state === 3'd3 && width !== prev) begin
        e = int'(prev) - int'(RAMP_STEP);
        if (e < 0) e = 0;
        total++; if (width !== e[19:0]) begin bad++; $display("FAIL coast_step got=%0d want=%0d", width, e); end
        total++; if (pwm_en !== 1'b1) begin bad++; $display("FAIL coast_pwm_en got=%0b want=1", pwm_en); end
        prev = width;
      end
    end
    total++; if (state !== 3'd4) begin bad++; $display("FAIL swap_dead got=%0d want=4", state); end
    dead = 0;
    for (int i = 0; i < 50 && state === 3'd4; i++) begin
      dead++;
      total++; if (pwm_en !== 1'b0 || width !== 20'd0) begin bad++; $display("FAIL dead_drive got=%0b/%0d want=0/0", pwm_en, width); end
      step();
    end
    total++; if (dead != int'(DEAD_CYCLES)) begin bad++; $display("FAIL dead_len got=%0d want=%0d", dead, DEAD_CYCLES); end
    total++; if (dir !== 1'b1) begin bad++; $display("FAIL swap_dir got=%0b want=1", dir); end
    total++; if (state !== 3'd1) begin bad++; $display("FAIL swap_reramp got=%0d want=1", state); end
    wait_state(3'd2, 300, n);
    total++; if (n < 0 || width !== tgt) begin bad++; $display("FAIL swap_run_width got=%0d want=%0d", width, tgt); end
  endtask

  task automatic test_fault_pulse();
    int n;
    cin = 1'b1; step(); cin = 1'b0;
    step();
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL fault_early got=%0b want=0", fault); end
    step();
    total++; if (fault !== 1'b1)  begin bad++; $display("FAIL fault_set got=%0b want=1", fault); end
    total++; if (width !== 20'd0) begin bad++; $display("FAIL fault_width got=%0d want=0", width); end
    total++; if (pwm_en !== 1'b0) begin bad++; $display("FAIL fault_pwm_en got=%0b want=0", pwm_en); end
    total++; if (state !== 3'd5)  begin bad++; $display("FAIL fault_state got=%0d want=5", state); end
    for (int i = 1; i < int'(FAULT_HOLD); i++) begin
      step();
      total++; if (fault !== 1'b1) begin bad++; $display("FAIL fault_hold_early got=%0b want=1", fault); end
    end
    step();
    total++; if (fault !== 1'b0 || state !== 3'd0) begin bad++; $display("FAIL fault_exit got=%0b/%0d want=0/0", fault, state); end
    wait_state(3'd2, 300, n);
    total++; if (n < 0 || width !== ref_target(7'h04)) begin bad++; $display("FAIL fault_reramp got=%0d want=%0d", width, ref_target(7'h04)); end
  endtask

  task automatic test_duty_zero();
    logic [19:0] prev;
    int e;
    bit saw_dead;
    duty_sel = 7'd0;
    prev = width; saw_dead = 1'b0;
    for (int i = 0; i < 300 && state !== 3'd0; i++) begin
      step();
      if (state === 3'd4) saw_dead = 1'b1;
      if (state === 3'd3 && width !== prev) begin
        e = int'(prev) - int'(RAMP_STEP);
        if (e < 0) e = 0;
        total++; if (width !== e[19:0]) begin bad++; $display("FAIL stop_step got=%0d want=%0d", width, e); end
        prev = width;
      end
    end
    total++; if (state !== 3'd0 || saw_dead) begin bad++; $display("FAIL stop_idle got=%0d/%0b want=0/0", state, saw_dead); end
    total++; if (pwm_en !== 1'b0 || width !== 20'd0) begin bad++; $display("FAIL stop_drive got=%0b/%0d want=0/0", pwm_en, width); end
    total++; if (dir !== 1'b1) begin bad++; $display("FAIL stop_dir got=%0b want=1", dir); end
  endtask

  task automatic test_saturate();
    logic [19:0] tgt, prev;
    int n, e;
    bit sat, done;
    tgt = ref_target(7'h41);
    duty_sel = 7'h41;
    wait_state(3'd1, 10, n);
    total++; if (n < 0) begin bad++; $display("FAIL sat_entry got=%0d want=1", state); end
    prev = width; sat = 1'b0; done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      total++; if (width < prev) begin bad++; $display("FAIL sat_monotonic got=%0d want>=%0d", width, prev); end
      if (width !== prev) begin
        e = int'(prev) + int'(RAMP_STEP);
        if (e > int'(tgt)) begin e = int'(tgt); sat = 1'b1; end
        total++; if (width !== e[19:0]) begin bad++; $display("FAIL sat_step got=%0d want=%0d", width, e); end
        prev = width;
      end
      if (state === 3'd2) done = 1'b1;
    end
    total++; if (!done || width !== tgt) begin bad++; $display("FAIL sat_final got=%0d want=%0d", width, tgt); end
    total++; if (!sat) begin bad++; $display("FAIL sat_clipped got=%0b want=1", sat); end
  endtask

  task automatic test_reset_midramp();
    int n, since;
    bit hit;
    reset = 1'b0; step(); reset = 1'b1;
    duty_sel = 7'h04; dir_req = 1'b1;
    wait_state(3'd1, 10, n);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      step();
      if (state === 3'd1 && width >= 20'd131072) hit = 1'b1;
    end
    total++; if (!hit) begin bad++; $display("FAIL mid_ramp_reach got=%0d want>=131072", width); end
    reset = 1'b0; step(); reset = 1'b1;
    total++; if (width !== 20'd0 || state !== 3'd0) begin bad++; $display("FAIL mid_reset got=%0d/%0d want=0/0", width, state); end
    total++; if (pwm_en !== 1'b0 || dir !== 1'b0) begin bad++; $display("FAIL mid_reset_out got=%0b/%0b want=0/0", pwm_en, dir); end
    step();
    total++; if (state !== 3'd1 || width !== 20'd0) begin bad++; $display("FAIL restart_ramp got=%0d/%0d want=1/0", state, width); end
    total++; if (dir !== 1'b1) begin bad++; $display("FAIL restart_dir got=%0b want=1", dir); end
    since = 0;
    for (int i = 0; i < int'(RAMP_DIV) + 3 && width === 20'd0; i++) begin step(); since++; end
    total++; if (width !== RAMP_STEP || since != int'(RAMP_DIV)) begin bad++; $display("FAIL restart_first_step got=%0d@%0d want=%0d@%0d", width, since, RAMP_STEP, RAMP_DIV); end
  endtask

  task automatic test_fault_hold();
    cin2 = 1'b1;
    repeat (3) step();
    total++; if (state !== 3'd5) begin bad++; $display("FAIL hold_enter got=%0d want=5", state); end
    for (int i = 0; i < 100; i++) begin
      step();
      total++; if (state !== 3'd5 || fault !== 1'b1) begin bad++; $display("FAIL hold_stuck got=%0d/%0b want=5/1", state, fault); end
    end
    cin2 = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      step();
      total++; if (state !== 3'd5) begin bad++; $display("FAIL hold_release_early got=%0d want=5 at=%0d", state, i); end
    end
    step();
    total++; if (state !== 3'd0 || fault !== 1'b0) begin bad++; $display("FAIL hold_release got=%0d/%0b want=0/0", state, fault); end
  endtask

  task automatic test_random();
    logic [19:0] pw;
    logic [2:0]  ps;
    logic        pd, hi, dr;
    int since, dead_run, pulse_left, d, n;
    bit which;
    since = 1000; dead_run = 0; pulse_left = 0; which = 1'b0;
    pw = width; ps = state; pd = dir;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 59) == 0) duty_sel = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 199) == 0) dir_req = ~dir_req;
      if (pulse_left == 0 && $urandom_range(0, 399) == 0) begin
        pulse_left = $urandom_range(1, 3);
        which = 1'($urandom_range(0, 1));
      end
      cin  = (pulse_left > 0) && !which;
      cin2 = (pulse_left > 0) && which;
      if (pulse_left > 0) pulse_left--;
      hi = cin | cin2; dr = dir_req;
      step();
      if (hi) since = 0; else since++;
      if (since >= 2) begin
        total++; if ((state === 3'd5) != (since <= 17)) begin bad++; $display("FAIL rnd_fault_timing got=%0d want_fault=%0b since=%0d", state, since <= 17, since); end
      end
      total++; if (fault !== (state === 3'd5)) begin bad++; $display("FAIL rnd_fault_flag got=%0b state=%0d", fault, state); end
      total++; if (pwm_en !== (state === 3'd1 || state === 3'd2 || state === 3'd3)) begin bad++; $display("FAIL rnd_pwm_en got=%0b state=%0d", pwm_en, state); end
      if (state === 3'd0 || state === 3'd4 || state === 3'd5) begin
        total++; if (width !== 20'd0) begin bad++; $display("FAIL rnd_zero_width got=%0d state=%0d", width, state); end
      end
      d = int'(width) - int'(pw);
      if (d < 0) d = -d;
      total++; if (state !== 3'd5 && d > int'(RAMP_STEP)) begin bad++; $display("FAIL rnd_glitch got=%0d prev=%0d", width, pw); end
      if (dir !== pd) begin
        total++; if (!(ps === 3'd0 || ps === 3'd4) || dir !== dr) begin bad++; $display("FAIL rnd_dir_change got=%0b from_state=%0d want=%0b", dir, ps, dr); end
      end
      if (state === 3'd4) dead_run++;
      else begin
        if (dead_run > 0 && state !== 3'd5) begin
          total++; if (dead_run != int'(DEAD_CYCLES)) begin bad++; $display("FAIL rnd_dead_len got=%0d want=%0d", dead_run, DEAD_CYCLES); end
        end
        dead_run = 0;
      end
      pw = width; ps = state; pd = dir;
    end
    cin = 1'b0; cin2 = 1'b0;
    duty_sel = 7'($urandom_range(1, 127));
    repeat (600) step();
    n = 0;
    total++; if (state !== 3'd2 || width !== ref_target(duty_sel) || dir !== dir_req) begin bad++; $display("FAIL rnd_settle got=%0d/%0d/%0b want=2/%0d/%0b", state, width, dir, ref_target(duty_sel), dir_req); end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_dir_swap();
    test_fault_pulse();
    test_duty_zero();
    test_saturate();
    test_reset_midramp();
    test_fault_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/motor_sequencer.md
MOTOR_SEQUENCER -- requirements
Module: motor_sequencer

Interface
REQ-001 The block SHALL have parameter RAMP_DIV, default 4, meaning clocks per ramp step (>=1).
REQ-002 The block SHALL have parameter RAMP_STEP, default 20'd65536, meaning width change per ramp step.
REQ-003 The block SHALL have parameter DEAD_CYCLES, default 8, meaning clocks with drive disabled before a direction swap.
REQ-004 The block SHALL have parameter FAULT_HOLD, default 16, meaning clocks of clear comparators required before fault exit.
REQ-005 The block SHALL have port `clock`, input, 1 bit: the single clock; all logic is on its posedge.
REQ-006 The block SHALL have port `reset`, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-007 The block SHALL have port `dir_req`, input, 1 bit: requested direction (0 forward, 1 backward).
REQ-008 The block SHALL have port `duty_sel`, input, 7 bits: duty switches; bit k selects level k+1.
REQ-009 The block SHALL have port `cin`, input, 1 bit: asynchronous overcurrent comparator A.
REQ-010 The block SHALL have port `cin2`, input, 1 bit: asynchronous overcurrent comparator B.
REQ-011 The block SHALL have port `width`, output, 20 bits: current PWM compare width, registered.
REQ-012 The block SHALL have port `dir`, output, 1 bit: applied direction, registered.
REQ-013 The block SHALL have port `pwm_en`, output, 1 bit: drive enable; PWM outputs are forced low when 0.
REQ-014 The block SHALL have port `fault`, output, 1 bit: latched overcurrent indication.
REQ-015 The block SHALL have port `state`, output, 3 bits: state encoding, for the seven-segment display.

Function
REQ-016 The target width SHALL be decoded from the highest set duty_sel bit: none=0, b0=262143, b1=393215, b2=524287, b3=655359, b4=786431, b5=917503, b6=1048575.
REQ-017 cin and cin2 SHALL each pass through a 2-flop synchronizer; oc = the OR of the synchronized values, so oc lags the inputs by 2 clocks.
REQ-018 States SHALL be IDLE=0, RAMP=1, RUN=2, COAST=3, DEAD=4, FAULT=5.
REQ-019 A ramp tick SHALL pulse once every RAMP_DIV clocks; the tick counter restarts on any state change.
REQ-020 IDLE: width=0 and pwm_en=0; when target!=0, dir SHALL be loaded from dir_req and the state SHALL go to RAMP.
REQ-021 RAMP: pwm_en=1; on each tick, width SHALL become min(width+RAMP_STEP, target), computed without 20-bit overflow (21-bit sum, saturating).
REQ-022 RAMP/RUN: if target<width, the state SHALL go to COAST; when width==target, RAMP SHALL go to RUN.
REQ-023 RUN: width is held; if target>width, the state SHALL go to RAMP.
REQ-024 RAMP/RUN: if dir_req!=dir, the state SHALL go to COAST with an effective target of 0.
REQ-025 COAST: on each tick, width SHALL become max(width-RAMP_STEP, goal) with no underflow; goal is 0 on a direction change or target 0, otherwise the new target.
REQ-026 COAST exit, evaluated when width reaches goal: direction mismatch -> DEAD; goal==0 -> IDLE; otherwise -> RUN.
REQ-027 DEAD: pwm_en=0 and width=0 for exactly DEAD_CYCLES clocks; then dir<=dir_req and the state SHALL go to RAMP, or to IDLE if target==0.
REQ-028 oc=1 in any state SHALL cause, on the next clock, state=FAULT, width=0, pwm_en=0 and fault=1; this has priority over every other transition.
REQ-029 FAULT: a hold counter SHALL clear whenever oc=1; after FAULT_HOLD consecutive clocks with oc=0, the block SHALL go to IDLE and clear fault.
REQ-030 A dir_req toggle during DEAD SHALL not restart DEAD; dir SHALL take dir_req as sampled at DEAD exit.
REQ-031 duty_sel changes SHALL be applied without glitches: width moves only by ramp steps, except the forced zeroing in FAULT.

Reset
REQ-032 While reset=0 at a posedge: state=IDLE, width=0, dir=0, pwm_en=0, fault=0, all counters=0, synchronizers=0.
REQ-033 Reset asserted mid-ramp or mid-fault SHALL take effect on the same edge, overriding all transitions.

Structure
REQ-034 Package motor_pkg SHALL hold the state encoding, the eight duty-width constants, and the width of 20.
REQ-035 Sub-module ramp_tick SHALL hold the RAMP_DIV counter and tick output, with a restart input; all other logic stays in motor_sequencer.

Verification
REQ-036 Reset, then duty_sel=7'h04 with dir_req=0 -> RAMP; width goes 0, 65536, ... every 4 clocks, saturates at 524287, then RUN; pwm_en=1; dir=0.
REQ-037 In RUN at 524287, toggle dir_req to 1 -> COAST ramps width down to 0, then DEAD holds pwm_en=0 for 8 clocks, then dir=1 and RAMP back to 524287.
REQ-038 In RUN, pulse cin=1 for 1 clock -> 3 clocks later fault=1, width=0, pwm_en=0; fault clears 16 clocks after oc drops; state=IDLE, then re-ramps.
REQ-039 duty_sel=7'h41 (b6 and b0 set) -> target 1048575; the final ramp step saturates without wrap (width never < previous value).
REQ-040 In RAMP, drive reset=0 for 1 clock -> the next cycle shows width=0, state=0, pwm_en=0; with duty_sel still set, the ramp restarts from 0.
REQ-041 Set duty_sel=0 in RUN -> COAST to width 0, then IDLE; hold cin2=1 throughout FAULT -> FAULT is never exited.
